div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 173 +++++++++++++++++
 tb/tb_div_iter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider, signed or unsigned.
//
// One operation at a time. Each operation takes a fixed number of cycles:
// WIDTH CALC steps, one FIX step for sign and exception correction, then DONE,
// where the result is held until the consumer takes it.
//
// Ports
//   clk        : clock, every state update happens on its rising edge
//   rst        : synchronous active-high reset
//   in_valid   : dividend / divisor / is_signed are valid
//   in_ready   : high in IDLE only; an accept is in_valid & in_ready & !flush
//   dividend   : numerator, WIDTH bits
//   divisor    : denominator, WIDTH bits
//   is_signed  : 1 = two's-complement operands, 0 = unsigned
//   flush      : abort any operation in flight and return to IDLE
//   out_valid  : quotient / remainder are valid (DONE state)
//   out_ready  : the consumer takes the result
//   quotient   : result quotient, held at its last value outside DONE
//   remainder  : result remainder, held at its last value outside DONE
// ---------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;          // partial remainder
    logic [WIDTH-1:0] r_quo;          // holds |dividend| bits, becomes quotient
    logic [WIDTH-1:0] r_div;          // |divisor|
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_dividend;     // raw operands, needed for divide-by-zero
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

    // flush wins over a simultaneous request in IDLE
    assign w_accept = in_valid && (r_state == IDLE) && !flush;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Magnitudes; the most negative value maps onto itself, which read as an
    // unsigned magnitude is exactly right.
    assign w_abs_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_abs_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and trial-subtract. The partial remainder is always below the
    // divisor, so the WIDTH+1-bit difference has its top bit set exactly when
    // the trial goes negative.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // -------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = CALC;
            CALC: if (w_last) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush) begin
            w_state_next = IDLE;
        end
    end

    // -------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_abs_a;
                        r_div      <= w_abs_b;
                        r_neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= is_signed && dividend[WIDTH-1];
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                    end
                end
                CALC: begin
                    if (w_diff[WIDTH]) begin
                        r_rem <= w_shift[WIDTH-1:0];          // restore
                    end else begin
                        r_rem <= w_diff[WIDTH-1:0];
                    end
                    r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    // Divide-by-zero is forced here rather than trusting the
                    // loop, since the sign fix would otherwise corrupt it.
                    if (r_divisor == '0) begin
                        r_quotient  <= '1;
                        r_remainder <= r_dividend;
                    end else begin
                        r_quotient  <= r_neg_q ? -r_quo : r_quo;
                        r_remainder <= r_neg_r ? -r_rem : r_rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter -- self-checking bench for div_iter (WIDTH = 32).
// Directed cases plus randomized operations compared with a behavioural
// reference built on plain integer division.
// ---------------------------------------------------------------------------
module tb_div_iter;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Truncating division with the two defined exception results.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Accept one operation, measure latency, check the result, hold out_ready
    // low for 'hold' cycles, then complete the handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                          input int hold, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           period;
        ref_div(a, b, sg, eq, er);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);                     // accept edge
        @(negedge clk);
        in_valid  = 1'b0;
        dividend  = $urandom;               // operands must have been captured
        divisor   = $urandom;
        is_signed = 1'($urandom);
        period = 1;
        while (!out_valid && period < 100) begin
            @(negedge clk);
            period++;
        end
        chk({tag, "_latency"}, 64'(period), 64'(LAT));
        chk({tag, "_q"}, 64'(quotient), 64'(eq));
        chk({tag, "_r"}, 64'(remainder), 64'(er));
        $display("op %s: %0h / %0h signed=%0d -> q=%0h r=%0h lat=%0d",
                 tag, a, b, sg, quotient, remainder, period);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
            chk({tag, "_hold_q"}, 64'(quotient), 64'(eq));
            chk({tag, "_hold_r"}, 64'(remainder), 64'(er));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_post_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sg;
        int           cnt;
        int           mode;

        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_q", 64'(quotient), 64'd0);
        chk("reset_r", 64'(remainder), 64'd0);
        rst = 1'b0;

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s_7_m2");
        run_op(32'h1234_5678, 32'd0, 1'b1, 0, "s_divzero");
        run_op(32'h1234_5678, 32'd0, 1'b0, 0, "u_divzero");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_ovf_ops");
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1, "s_neg_divzero");
        run_op(32'd1000, 32'd33, 1'b0, 5, "hold5");

        // flush and in_valid together in IDLE: flush wins, no accept
        @(negedge clk);
        dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_ready", 64'(in_ready), 64'd1);
        $display("op flush_idle: in_ready=%0d", in_ready);

        // flush in CALC cycle 10
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);                     // CALC cycle 1
        in_valid = 1'b0;
        repeat (9) @(negedge clk);          // CALC cycle 10
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_calc_ready", 64'(in_ready), 64'd1);
        chk("flush_calc_valid", 64'(out_valid), 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("flush_calc_no_pulse", 64'(cnt), 64'd0);
        $display("op flush_calc: stray out_valid cycles=%0d", cnt);
        run_op(32'd9, 32'd3, 1'b0, 0, "after_flush");

        // reset while in DONE
        @(negedge clk);
        dividend = 32'd77; divisor = 32'd5; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_done_reached", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_valid", 64'(out_valid), 64'd0);
        chk("rst_done_ready", 64'(in_ready), 64'd1);
        chk("rst_done_q", 64'(quotient), 64'd0);
        chk("rst_done_r", 64'(remainder), 64'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("rst_done_no_pulse", 64'(cnt), 64'd0);
        $display("op rst_done: q=%0h r=%0h", quotient, remainder);
        run_op(32'd9, 32'd3, 1'b0, 0, "after_rst");

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 5));
            sg   = 1'($urandom);
            a    = $urandom;
            b    = $urandom;
            case (mode)
                1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                2: b = '0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin
                    b = $urandom_range(1, 1000);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                5: b = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF;
                default: begin end
            endcase
            run_op(a, b, sg, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
